out_fifo: RTL and testbench
===========================

# out_fifo

Parametrised output unit for the SAP-1 datapath, successor to the single-byte output register. It captures data-bus bytes when the control word asserts nLo and keeps the most recent byte on a display bus. Each captured byte is also queued in a DEPTH-entry FIFO, so an external consumer (UART, LED scanner, test harness) can drain OUT instructions at its own rate through a valid/ready handshake. Overflow is flagged and held instead of being silently overwritten.

## Interface
- WIDTH, 8: data width of DBUS, OBUS and ODATA.
- DEPTH, 4: FIFO entries. Must be a power of two, at least 2.
- CLK  input  1  system clock. All state changes on the falling edge, matching the rest of the datapath.
- CLR  input  1  reset, asynchronous, active-high.
- nLo  input  1  active-low load strobe from the control word.
- DBUS  input  WIDTH  data bus.
- OBUS  output  WIDTH  display register holding the last loaded byte.
- ODATA  output  WIDTH  FIFO head, first-word fall-through.
- OVALID  output  1  ODATA is valid (FIFO not empty).
- ORDY  input  1  consumer accepts ODATA.
- FULL  output  1  COUNT == DEPTH.
- EMPTY  output  1  COUNT == 0.
- COUNT  output  $clog2(DEPTH)+1  current occupancy.
- OVF  output  1  sticky overflow flag.

## Operation
- Reset (CLR=1, async): OBUS=0, ODATA=0, OVALID=0, FULL=0, EMPTY=1, COUNT=0, OVF=0. Read and write pointers go to 0. Memory contents are don't-care and are never visible.
- Load = (nLo==0) sampled at the falling edge of CLK.
- Pop = OVALID && ORDY sampled at the same edge.
- On load, OBUS <= DBUS unconditionally, including when the FIFO is full.
- Push (queue side):
  - When load && (!FULL || pop): mem[wptr] <= DBUS, wptr increments modulo DEPTH.
  - When load && FULL && !pop: the byte is not queued, queue contents are unchanged, and OVF <= 1.
- Pop: rptr increments modulo DEPTH.
- Occupancy: COUNT += push − pop.
  - Push and pop together leave COUNT unchanged. This is legal when full: head leaves and the new byte enters.
  - When empty, OVALID=0, so a load in that cycle is a push only. The byte becomes visible on ODATA after that edge.
- ODATA = mem[rptr] when !EMPTY, else 0. ODATA is combinational from the pointers and memory.
- OVALID = !EMPTY. FULL and EMPTY are decoded from COUNT.
- OVF clears only on CLR.
- Pointers are $clog2(DEPTH) bits and wrap naturally. COUNT distinguishes full from empty.
- ORDY is ignored while OVALID=0. ORDY may be held high permanently, giving a drain rate of one byte per cycle.

## Timing
- Load to OBUS: updates at the falling edge where nLo=0. Zero added latency, same as the legacy register.
- Load to OVALID/ODATA: valid immediately after the same falling edge, provided the FIFO was empty.
- Pop: the next head appears on ODATA immediately after the falling edge on which OVALID && ORDY. OVALID drops at that edge if the FIFO becomes empty.
- Consumer handshake:
  - The consumer may change ORDY at any time.
  - The handshake counts only at a falling edge.
  - The consumer must sample ODATA/OVALID on the rising edge or combinationally before the falling edge.
- Throughput: one push and one pop per cycle.
- CLR mid-operation:
  - All outputs reach reset values asynchronously, without waiting for a clock edge.
  - An in-flight load or pop in that cycle is discarded.
  - The first falling edge after CLR deasserts operates normally.

## Test plan
- Reset, then nLo=0 with DBUS=0xA5 for one edge -> OBUS=0xA5, OVALID=1, ODATA=0xA5, COUNT=1, EMPTY=0.
- With ORDY=0, load 0x01, 0x02, 0x03, 0x04 -> FULL=1, COUNT=4. Then load 0x05 -> OBUS=0x05, OVF=1, COUNT=4. Then ORDY=1 for 4 edges -> ODATA sequence 0x01, 0x02, 0x03, 0x04, ending EMPTY=1, ODATA=0.
- Full FIFO, ORDY=1 with load 0x55 in the same edge -> COUNT stays 4, OVF unchanged, 0x55 drains last.
- ORDY=1 permanently, 10 consecutive loads 0x10..0x19 -> each byte appears on ODATA one edge after its load, COUNT toggles 0/1 only, OVF=0. Pointers wrap past DEPTH without error.
- Assert CLR asynchronously between edges with COUNT=3 and OVF=1 -> all outputs go to reset values before the next edge. The next load 0x7E -> COUNT=1, ODATA=0x7E.
- Parameter sweep (WIDTH=16, DEPTH=8): fill with 0x1234.., overflow once, drain -> FIFO order preserved, COUNT reaches 8, OVF=1.

Source files
------------

// File: rtl/out_fifo.sv
// SAP-1 output unit: display register plus a DEPTH-entry first-word fall-through
// queue drained by a valid/ready consumer. All state changes on the falling edge.
module out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     nLo,
    input  logic [WIDTH-1:0]         DBUS,
    output logic [WIDTH-1:0]         OBUS,
    output logic [WIDTH-1:0]         ODATA,
    output logic                     OVALID,
    input  logic                     ORDY,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVF
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("out_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count_q;
    logic             load;
    logic             pop;
    logic             push;

    always_comb begin
        load   = !nLo;
        EMPTY  = (count_q == '0);
        FULL   = (count_q == CW'(DEPTH));
        OVALID = !EMPTY;
        COUNT  = count_q;
        pop    = OVALID && ORDY;
        // A simultaneous pop frees the slot, so a full queue still accepts the byte.
        push   = load && (!FULL || pop);
        ODATA  = EMPTY ? '0 : mem[rptr];
    end

    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            OBUS    <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            OVF     <= 1'b0;
        end else begin
            if (load) begin
                OBUS <= DBUS;
            end
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (load && !push) begin
                OVF <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; stale entries are masked by COUNT.
    always_ff @(negedge CLK) begin
        if (push && !CLR) begin
            mem[wptr] <= DBUS;
        end
    end

endmodule

// File: tb/tb_out_fifo.sv
// Scoreboard bench for out_fifo: two instances (8x4 and 16x8) driven in lockstep
// and checked against a queue-based reference model.
module tb_out_fifo;

    logic        CLK;
    logic        CLR;
    logic        nLo;
    logic        ORDY;
    logic [15:0] DBUS;

    logic [7:0]  a_obus, a_odata;
    logic        a_ovalid, a_full, a_empty, a_ovf;
    logic [2:0]  a_count;
    logic [15:0] b_obus, b_odata;
    logic        b_ovalid, b_full, b_empty, b_ovf;
    logic [3:0]  b_count;

    out_fifo #(.WIDTH(8), .DEPTH(4)) dut_a (
        .CLK(CLK), .CLR(CLR), .nLo(nLo), .DBUS(DBUS[7:0]),
        .OBUS(a_obus), .ODATA(a_odata), .OVALID(a_ovalid), .ORDY(ORDY),
        .FULL(a_full), .EMPTY(a_empty), .COUNT(a_count), .OVF(a_ovf)
    );

    out_fifo #(.WIDTH(16), .DEPTH(8)) dut_b (
        .CLK(CLK), .CLR(CLR), .nLo(nLo), .DBUS(DBUS),
        .OBUS(b_obus), .ODATA(b_odata), .OVALID(b_ovalid), .ORDY(ORDY),
        .FULL(b_full), .EMPTY(b_empty), .COUNT(b_count), .OVF(b_ovf)
    );

    initial begin
        CLK = 1'b1;
        forever #10 CLK = ~CLK;
    end

    logic [15:0] obus_x  [2];
    logic [15:0] odata_x [2];
    logic [3:0]  count_x [2];
    logic        ovalid_x[2];
    logic        full_x  [2];
    logic        empty_x [2];
    logic        ovf_x   [2];

    assign obus_x[0]   = {8'h00, a_obus};
    assign obus_x[1]   = b_obus;
    assign odata_x[0]  = {8'h00, a_odata};
    assign odata_x[1]  = b_odata;
    assign count_x[0]  = {1'b0, a_count};
    assign count_x[1]  = b_count;
    assign ovalid_x[0] = a_ovalid;
    assign ovalid_x[1] = b_ovalid;
    assign full_x[0]   = a_full;
    assign full_x[1]   = b_full;
    assign empty_x[0]  = a_empty;
    assign empty_x[1]  = b_empty;
    assign ovf_x[0]    = a_ovf;
    assign ovf_x[1]    = b_ovf;

    // Reference model: a plain queue per instance plus the display byte and sticky flag.
    int          depth  [2] = '{4, 8};
    logic [15:0] mask   [2] = '{16'h00FF, 16'hFFFF};
    logic [15:0] mq     [2][$];
    logic [15:0] sb     [2][$];
    logic [15:0] obus_m [2];
    bit          ovf_m  [2];

    bit          pend;
    bit          pend_ld;
    bit          pend_rdy;
    logic [15:0] pend_d;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d] @%0t: got %0h expected %0h", nm, inst, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            sb[i].delete();
            obus_m[i] = '0;
            ovf_m[i]  = 1'b0;
        end
        pend = 1'b0;
    endtask

    // Applies the inputs consumed at the falling edge that just passed.
    task automatic commit();
        if (pend) begin
            for (int i = 0; i < 2; i++) begin
                bit          p;
                bit          w;
                logic [15:0] v;
                v = pend_d & mask[i];
                p = (mq[i].size() > 0) && pend_rdy;
                w = pend_ld && ((mq[i].size() < depth[i]) || p);
                if (pend_ld) obus_m[i] = v;
                if (pend_ld && !w) ovf_m[i] = 1'b1;
                if (p) void'(mq[i].pop_front());
                if (w) begin
                    mq[i].push_back(v);
                    sb[i].push_back(v);
                end
            end
            pend = 1'b0;
        end
    endtask

    task automatic step(input bit ld, input logic [15:0] d, input bit rdy);
        @(negedge CLK);
        #2;
        commit();
        nLo      = !ld;
        DBUS     = d;
        ORDY     = rdy;
        pend     = 1'b1;
        pend_ld  = ld;
        pend_d   = d;
        pend_rdy = rdy;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_obus"},   i, obus_x[i],   0);
            chk({tag, "_odata"},  i, odata_x[i],  0);
            chk({tag, "_ovalid"}, i, ovalid_x[i], 0);
            chk({tag, "_full"},   i, full_x[i],   0);
            chk({tag, "_empty"},  i, empty_x[i],  1);
            chk({tag, "_count"},  i, count_x[i],  0);
            chk({tag, "_ovf"},    i, ovf_x[i],    0);
        end
    endtask

    // CLR pulse between edges; the pending transfer is discarded.
    task automatic do_clear();
        @(posedge CLK);
        #4;
        CLR = 1'b1;
        #2;
        check_reset_outputs("clr");
        nLo  = 1'b1;
        ORDY = 1'b0;
        model_reset();
        @(negedge CLK);
        #4;
        CLR = 1'b0;
    endtask

    always @(posedge CLK) begin
        if (started && !CLR) begin
            for (int i = 0; i < 2; i++) begin
                chk("count",  i, count_x[i],  mq[i].size());
                chk("ovalid", i, ovalid_x[i], mq[i].size() > 0);
                chk("empty",  i, empty_x[i],  mq[i].size() == 0);
                chk("full",   i, full_x[i],   mq[i].size() == depth[i]);
                chk("ovf",    i, ovf_x[i],    ovf_m[i]);
                chk("obus",   i, obus_x[i],   obus_m[i]);
                if (mq[i].size() > 0) chk("odata_head", i, odata_x[i], mq[i][0]);
                else                  chk("odata_idle", i, odata_x[i], 0);
                if (ovalid_x[i] && ORDY) begin
                    if (sb[i].size() == 0) chk("pop_unexpected", i, 1, 0);
                    else                   chk("pop_data", i, odata_x[i], sb[i].pop_front());
                end
            end
        end
    end

    initial begin
        CLR  = 1'b1;
        nLo  = 1'b1;
        ORDY = 1'b0;
        DBUS = '0;
        model_reset();
        #5;
        check_reset_outputs("rst");
        repeat (2) @(negedge CLK);
        #4;
        CLR     = 1'b0;
        started = 1'b1;

        step(1, 16'h00A5, 0);
        step(0, 16'h0000, 1);
        for (int k = 1; k <= 4; k++) step(1, 16'(k), 0);
        step(1, 16'h0005, 0);
        for (int k = 0; k < 4; k++) step(0, 16'h0000, 1);
        step(0, 16'h0000, 0);

        for (int k = 1; k <= 4; k++) step(1, 16'h0040 + 16'(k), 0);
        step(1, 16'h0055, 1);
        for (int k = 0; k < 5; k++) step(0, 16'h0000, 1);

        for (int k = 0; k < 10; k++) step(1, 16'h0010 + 16'(k), 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 0);

        for (int k = 1; k <= 3; k++) step(1, 16'h0030 + 16'(k), 0);
        step(0, 16'h0000, 0);
        do_clear();
        step(1, 16'h007E, 0);
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 1);

        for (int k = 0; k < 9; k++) step(1, 16'h1234 + 16'(k), 0);
        for (int k = 0; k < 10; k++) step(0, 16'h0000, 1);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 49) == 0) do_clear();
            step($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 45);
        end

        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);
        @(posedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
